// File: rtl/lockpick_result_sink.sv
// rtl/lockpick_result_sink.sv - checks, counts and buffers lockpick result bursts; option macro LOCKPICK_PATTERN_CHECK_EN
module lockpick_result_sink #(
    parameter int FRAME_BYTES = 32,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic [1:0]       in_status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             result_done,
    output logic [1:0]       result_code,
    output logic             frame_error,
    output logic             overrun,
    output logic [CNT_W-1:0] win_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] lock_count
);
    localparam int IW = $clog2(FRAME_BYTES);
    localparam logic [IW-1:0] LAST = IW'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [1:0]      status_q;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   rd_idx;
    logic [7:0]      frame_buf [FRAME_BYTES];
    logic            ign_q;
    logic            take_first, take_byte, last_byte, rd_fire, frame_mis;
    logic [1:0]      code_nxt;

    assign take_first = (state == IDLE) && in_valid && !ign_q;
    assign take_byte  = (state == CAPTURE) && in_valid;
    assign last_byte  = take_byte && (idx == LAST);
    assign rd_fire    = (state == DRAIN) && out_ready;

`ifdef LOCKPICK_PATTERN_CHECK_EN
    logic mismatch_q;
    logic byte_mis;

    function automatic logic pattern_miss(input logic [1:0] st, input logic odd, input logic [7:0] b);
        logic [7:0] e;
        logic       known;
        e     = 8'h00;
        known = 1'b1;
        case (st)
            2'b10:   e = odd ? 8'hFA : 8'hCE;
            2'b01:   e = odd ? 8'hBA : 8'hD0;
            2'b11:   e = odd ? 8'hDE : 8'hAD;
            default: known = 1'b0;
        endcase
        return !known || (b != e);
    endfunction

    // The first byte is judged against the live status, since status_q is loaded on that same edge.
    assign byte_mis = take_first ? pattern_miss(in_status, 1'b0, in_data)
                                 : pattern_miss(status_q, idx[0], in_data);

    always_ff @(posedge clk) begin
        if (rst)
            mismatch_q <= 1'b0;
        else if (take_first)
            mismatch_q <= byte_mis;
        else if (take_byte)
            mismatch_q <= mismatch_q | byte_mis;
    end

    assign frame_mis = mismatch_q | byte_mis;
`else
    logic mismatch_q;
    assign mismatch_q = 1'b0;
    assign frame_mis  = mismatch_q;
`endif

    assign code_nxt  = frame_mis ? 2'b00 : status_q;
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? frame_buf[rd_idx] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_first) state_nxt = CAPTURE;
            CAPTURE: begin
                if (!in_valid)
                    state_nxt = IDLE;
                else if (idx == LAST)
                    state_nxt = CHECK;
            end
            CHECK:   state_nxt = DRAIN;
            DRAIN:   if (rd_fire && (rd_idx == LAST)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (take_first)
            frame_buf[0] <= in_data;
        else if (take_byte)
            frame_buf[idx] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q    <= 2'b00;
            idx         <= '0;
            rd_idx      <= '0;
            ign_q       <= 1'b0;
            result_done <= 1'b0;
            result_code <= 2'b00;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            win_count   <= '0;
            err_count   <= '0;
            lock_count  <= '0;
        end else begin
            result_done <= 1'b0;
            // Long-frame tails and overrun frames stay ignored until in_valid goes low once.
            ign_q <= in_valid && (ign_q || (state == CHECK) || (state == DRAIN));
            if (take_first) begin
                status_q <= in_status;
                idx      <= IW'(1);
            end
            if (take_byte)
                idx <= idx + IW'(1);
            if ((state == CAPTURE) && !in_valid)
                frame_error <= 1'b1;
            if (last_byte) begin
                result_done <= 1'b1;
                result_code <= code_nxt;
                if (frame_mis)
                    frame_error <= 1'b1;
                case (code_nxt)
                    2'b10:   if (win_count  != '1) win_count  <= win_count  + CNT_W'(1);
                    2'b01:   if (err_count  != '1) err_count  <= err_count  + CNT_W'(1);
                    2'b11:   if (lock_count != '1) lock_count <= lock_count + CNT_W'(1);
                    default: ;
                endcase
            end
            if ((state == CHECK) && in_valid)
                frame_error <= 1'b1;
            if ((state == DRAIN) && in_valid && !ign_q)
                overrun <= 1'b1;
            if (state == CHECK)
                rd_idx <= '0;
            else if (rd_fire)
                rd_idx <= rd_idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_lockpick_result_sink.sv
// tb/tb_lockpick_result_sink.sv - randomized self-checking bench for lockpick_result_sink
module tb_lockpick_result_sink;
    localparam int FB  = 32;
    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;
`ifdef LOCKPICK_PATTERN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic [1:0]    in_status = 2'b00;
    logic          out_valid, out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          result_done, frame_error, overrun;
    logic [1:0]    result_code;
    logic [CW-1:0] win_count, err_count, lock_count;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sent [FB];
    int         m_win, m_err, m_lock;
    logic       m_ferr;
    logic [1:0] m_code;
    int         done_cnt, done_at;
    logic [1:0] code_seen;

    lockpick_result_sink #(.FRAME_BYTES(FB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_status(in_status),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .result_done(result_done), .result_code(result_code), .frame_error(frame_error),
        .overrun(overrun), .win_count(win_count), .err_count(err_count), .lock_count(lock_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pat(input logic [1:0] st, input int i);
        case (st)
            2'b10:   return (i % 2) ? 8'hFA : 8'hCE;
            2'b01:   return (i % 2) ? 8'hBA : 8'hD0;
            2'b11:   return (i % 2) ? 8'hDE : 8'hAD;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v >= MAX) ? MAX : v + 1;
    endfunction

    task automatic model_frame(input logic [1:0] st, input bit corrupted, input bit extra);
        bit mis;
        mis    = CHECK_EN && ((st == 2'b00) || corrupted);
        m_code = mis ? 2'b00 : st;
        if (mis || extra) m_ferr = 1'b1;
        case (m_code)
            2'b10:   m_win  = sat(m_win);
            2'b01:   m_err  = sat(m_err);
            2'b11:   m_lock = sat(m_lock);
            default: ;
        endcase
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_win = 0; m_err = 0; m_lock = 0; m_ferr = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] st, input int n, input int extra, input int cidx, input logic [7:0] cval);
        logic [7:0] d;
        done_cnt = 0; done_at = -1; code_seen = 2'b00;
        for (int i = 0; i < n + extra; i++) begin
            in_valid = 1'b1; in_status = st;
            if (i >= n) d = 8'($urandom);
            else begin
                d = pat(st, i);
                if (i == cidx) d = cval;
            end
            in_data = d;
            if (i < FB) sent[i] = d;
            @(posedge clk); #1;
            if (result_done) begin done_cnt++; done_at = i; code_seen = result_code; end
        end
        in_valid = 1'b0;
    endtask

    // mode 0: ready always, 1: ready pattern 1,0,0, 2: random; iv_start >= 0 raises in_valid from that drain cycle on
    task automatic drain_frame(input int mode, input int iv_start);
        int got = 0, cyc = 0, bad_order = 0, bad_hold = 0, dones = 0;
        logic [7:0] prev = 8'h00;
        bit stalled = 1'b0;
        while (got < FB && cyc < FB * 20) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
            if (iv_start >= 0 && cyc >= iv_start) begin in_valid = 1'b1; in_data = 8'($urandom); end
            if (stalled && out_valid && out_data !== prev) bad_hold++;
            if (result_done) dones++;
            if (out_valid && out_ready) begin
                if (out_data !== sent[got]) bad_order++;
                got++; stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1; prev = out_data;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        checks++; if (got !== FB) begin failures++; $display("FAIL drain_count: got %0d bytes, required %0d", got, FB); end
        checks++; if (bad_order !== 0) begin failures++; $display("FAIL drain_order: %0d wrong bytes, required 0", bad_order); end
        checks++; if (bad_hold !== 0) begin failures++; $display("FAIL drain_hold: %0d unstable stalls, required 0", bad_hold); end
        checks++; if (dones !== 0) begin failures++; $display("FAIL drain_done: %0d result_done pulses, required 0", dones); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_end: out_valid=%0b, required 0", out_valid); end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: %0b, required 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: %h, required 00", out_data); end
        checks++; if (result_done !== 1'b0) begin failures++; $display("FAIL reset_done: %0b, required 0", result_done); end
        checks++; if (result_code !== 2'b00) begin failures++; $display("FAIL reset_code: %b, required 00", result_code); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error: %0b, required 0", frame_error); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: %0b, required 0", overrun); end
        checks++; if ({win_count, err_count, lock_count} !== '0) begin failures++; $display("FAIL reset_counts: %0d/%0d/%0d, required 0/0/0", win_count, err_count, lock_count); end
    endtask

    task automatic test_win_frame();
        apply_reset();
        send_frame(2'b10, FB, 0, -1, 8'h00);
        model_frame(2'b10, 1'b0, 1'b0);
        checks++; if (done_at !== FB - 1) begin failures++; $display("FAIL win_latency: done at byte %0d, required %0d", done_at, FB - 1); end
        checks++; if (code_seen !== 2'b10) begin failures++; $display("FAIL win_code: %b, required 10", code_seen); end
        checks++; if (win_count !== CW'(m_win)) begin failures++; $display("FAIL win_count: %0d, required %0d", win_count, m_win); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL win_frame_error: %0b, required 0", frame_error); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL win_first_out: out_valid=%0b, required 1", out_valid); end
        drain_frame(0, -1);
    endtask

    task automatic test_corrupt_err();
        apply_reset();
        send_frame(2'b01, FB, 0, 7, 8'h00);
        model_frame(2'b01, 1'b1, 1'b0);
        checks++; if (code_seen !== m_code) begin failures++; $display("FAIL corrupt_code: %b, required %b", code_seen, m_code); end
        checks++; if (frame_error !== m_ferr) begin failures++; $display("FAIL corrupt_frame_error: %0b, required %0b", frame_error, m_ferr); end
        checks++; if (err_count !== CW'(m_err)) begin failures++; $display("FAIL corrupt_err_count: %0d, required %0d", err_count, m_err); end
        @(posedge clk); #1;
        drain_frame(0, -1);
    endtask

    task automatic test_short_frame();
        int dones = 0, ovs = 0;
        apply_reset();
        send_frame(2'b11, 20, 0, -1, 8'h00);
        dones = done_cnt;
        repeat (4) begin
            @(posedge clk); #1;
            if (result_done) dones++;
            if (out_valid) ovs++;
        end
        m_ferr = 1'b1;
        checks++; if (dones !== 0) begin failures++; $display("FAIL short_done: %0d pulses, required 0", dones); end
        checks++; if (frame_error !== 1'b1) begin failures++; $display("FAIL short_frame_error: %0b, required 1", frame_error); end
        checks++; if (lock_count !== CW'(0)) begin failures++; $display("FAIL short_lock_count: %0d, required 0", lock_count); end
        checks++; if (ovs !== 0) begin failures++; $display("FAIL short_out_valid: %0d cycles, required 0", ovs); end
        send_frame(2'b11, FB, 0, -1, 8'h00);
        model_frame(2'b11, 1'b0, 1'b0);
        checks++; if (done_at !== FB - 1) begin failures++; $display("FAIL short_recover: done at byte %0d, required %0d", done_at, FB - 1); end
        checks++; if (lock_count !== CW'(m_lock)) begin failures++; $display("FAIL short_recover_count: %0d, required %0d", lock_count, m_lock); end
        @(posedge clk); #1;
        drain_frame(0, -1);
    endtask

    task automatic test_stall_overrun();
        int bad = 0;
        apply_reset();
        send_frame(2'b10, FB, 0, -1, 8'h00);
        model_frame(2'b10, 1'b0, 1'b0);
        @(posedge clk); #1;
        drain_frame(1, 2);
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid || result_done) bad++;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bad !== 0) begin failures++; $display("FAIL overrun_ignored: %0d active cycles, required 0", bad); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag: %0b, required 1", overrun); end
        checks++; if (win_count !== CW'(m_win)) begin failures++; $display("FAIL overrun_win_count: %0d, required %0d", win_count, m_win); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL overrun_frame_error: %0b, required 0", frame_error); end
    endtask

    task automatic test_random();
        logic [1:0] st;
        bit corrupt, extra;
        int cidx;
        logic [7:0] cval;
        apply_reset();
        for (int f = 0; f < 24; f++) begin
            st      = 2'($urandom_range(0, 3));
            corrupt = (st != 2'b00) && ($urandom_range(0, 2) == 0);
            extra   = ($urandom_range(0, 3) == 0);
            cidx    = corrupt ? $urandom_range(0, FB - 1) : -1;
            cval    = pat(st, cidx) ^ (8'h01 << $urandom_range(0, 7));
            send_frame(st, FB, int'(extra), cidx, cval);
            model_frame(st, corrupt, extra);
            checks++; if (done_cnt !== 1 || done_at !== FB - 1) begin failures++; $display("FAIL rand_done[%0d]: %0d pulses at byte %0d, required 1 at %0d", f, done_cnt, done_at, FB - 1); end
            checks++; if (code_seen !== m_code) begin failures++; $display("FAIL rand_code[%0d]: %b, required %b", f, code_seen, m_code); end
            checks++; if ({win_count, err_count, lock_count} !== {CW'(m_win), CW'(m_err), CW'(m_lock)}) begin failures++; $display("FAIL rand_counts[%0d]: %0d/%0d/%0d, required %0d/%0d/%0d", f, win_count, err_count, lock_count, m_win, m_err, m_lock); end
            checks++; if (frame_error !== m_ferr) begin failures++; $display("FAIL rand_frame_error[%0d]: %0b, required %0b", f, frame_error, m_ferr); end
            if (!extra) begin @(posedge clk); #1; end
            drain_frame(2, -1);
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rand_overrun: %0b, required 0", overrun); end
    endtask

    task automatic test_saturation();
        int bad_codes = 0;
        apply_reset();
        for (int f = 0; f < 300; f++) begin
            send_frame(2'b11, FB, 0, -1, 8'h00);
            model_frame(2'b11, 1'b0, 1'b0);
            if (code_seen !== 2'b11 || done_cnt !== 1) bad_codes++;
            @(posedge clk); #1;
            drain_frame(0, -1);
        end
        checks++; if (bad_codes !== 0) begin failures++; $display("FAIL sat_codes: %0d bad frames, required 0", bad_codes); end
        checks++; if (lock_count !== CW'(m_lock) || m_lock !== MAX) begin failures++; $display("FAIL sat_lock_count: %0d, required %0d", lock_count, MAX); end
        checks++; if (win_count !== CW'(0) || err_count !== CW'(0)) begin failures++; $display("FAIL sat_other_counts: %0d/%0d, required 0/0", win_count, err_count); end
    endtask

    task automatic test_mid_reset();
        send_frame(2'b10, 10, 0, -1, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid, result_done, result_code, frame_error, overrun} !== 6'b0) begin failures++; $display("FAIL midrst_flags: %b, required 000000", {out_valid, result_done, result_code, frame_error, overrun}); end
        checks++; if ({win_count, err_count, lock_count} !== '0) begin failures++; $display("FAIL midrst_counts: %0d/%0d/%0d, required 0/0/0", win_count, err_count, lock_count); end
        rst = 1'b0;
        m_win = 0; m_err = 0; m_lock = 0; m_ferr = 1'b0;
        send_frame(2'b10, FB, 0, -1, 8'h00);
        model_frame(2'b10, 1'b0, 1'b0);
        checks++; if (done_at !== FB - 1 || code_seen !== 2'b10) begin failures++; $display("FAIL midrst_frame: done at %0d code %b, required %0d code 10", done_at, code_seen, FB - 1); end
        checks++; if (win_count !== CW'(m_win)) begin failures++; $display("FAIL midrst_win_count: %0d, required %0d", win_count, m_win); end
        @(posedge clk); #1;
        drain_frame(0, -1);
    endtask

    initial begin
        test_reset();
        test_win_frame();
        test_corrupt_err();
        test_short_frame();
        test_stall_overrun();
        test_random();
        test_saturation();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lockpick_result_sink.md
Name: lockpick_result_sink

Overview:
- Sits directly downstream of the lockpick game core.
- Consumes the core's 32-byte result burst (output_valid/output_data) together with its 2-bit status, and checks that the burst matches the message that status announces.
- Keeps saturating outcome counters and buffers the frame, so a host can read it back over a valid/ready byte port.
- Gives the game's outcome a single verified result code and a one-cycle done strobe.

Parameters:
- FRAME_BYTES, 32, bytes per result burst; power of two, 4..32.
- CNT_W, 8, width of each saturating outcome counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte strobe from the game core's output_valid.
- in_data  in  8  result byte from the game core's output_data.
- in_status  in  2  game status: 01 error, 10 win, 11 locked out, 00 idle.
- out_valid  out  1  a buffered frame byte is available to the host.
- out_ready  in  1  host accepts a byte when out_valid and out_ready are both high.
- out_data  out  8  buffered frame byte; byte 0 first.
- result_done  out  1  one-cycle pulse when a frame finishes checking.
- result_code  out  2  verified outcome; holds until the next result_done.
- frame_error  out  1  sticky; set by a short, long or corrupted frame; cleared only by rst.
- overrun  out  1  sticky; a frame arrived while the buffer was still draining; cleared only by rst.
- win_count  out  CNT_W  saturating count of verified wins.
- err_count  out  CNT_W  saturating count of verified error frames.
- lock_count  out  CNT_W  saturating count of verified lockouts.

Behaviour:
- Reset: all outputs are 0, state is IDLE, the byte index is 0 and the buffer contents are don't-care. rst asserted mid-frame or mid-drain abandons the operation immediately.
- FSM states: IDLE, CAPTURE, CHECK, DRAIN.
- IDLE:
  - in_valid=1 latches in_status into status_q, stores in_data at index 0, sets idx=1 and moves to CAPTURE.
  - A byte that is stored is also compared against the expected pattern.
- Expected pattern, by byte parity:
  - status 10: even bytes 0xCE, odd bytes 0xFA.
  - status 01: even bytes 0xD0, odd bytes 0xBA.
  - status 11: even bytes 0xAD, odd bytes 0xDE.
  - status 00: no pattern; the frame is always a mismatch.
  - Any mismatching byte sets mismatch_q for the frame.
- CAPTURE:
  - Each in_valid=1 cycle stores the byte at idx and increments idx.
  - On the FRAME_BYTES-th byte, go to CHECK.
  - in_valid=0 before then is a short frame: set frame_error, skip CHECK, discard the frame, return to IDLE. No result_done and no counter change.
- CHECK (exactly one cycle):
  - Pulse result_done.
  - result_code = status_q if mismatch_q=0; otherwise result_code = 00 and frame_error is set.
  - Increment the counter matching result_code; each counter saturates at all-ones, and code 00 touches no counter.
  - in_valid=1 during CHECK is a long frame: set frame_error. Extra bytes are ignored until in_valid drops.
  - Next state: DRAIN.
- DRAIN:
  - out_valid=1 and out_data=buf[rd_idx]; rd_idx advances on each handshake.
  - After handshake of byte FRAME_BYTES-1, drop out_valid and go to IDLE.
  - out_data is stable while out_valid=1 and out_ready=0.
- Overrun: in_valid=1 during DRAIN sets overrun. The incoming frame is ignored entirely; DRAIN continues, and bytes arriving after the return to IDLE are not captured until in_valid has been low for at least one cycle.
- Latency: result_done fires the cycle after the last frame byte is accepted; the first out_valid follows one cycle later.

Optional Feature:
- Macro: LOCKPICK_PATTERN_CHECK_EN.
- Defined: byte-pattern checking as described above.
- Undefined:
  - No comparators; mismatch_q is tied to 0.
  - result_code = status_q, including 00 for an idle status; frame_error comes only from short or long frames.
  - Counters still follow result_code.

Test Plan:
- in_status=10 with 32 cycles of CE,FA,CE,FA… -> result_done 1 cycle later, result_code=10, win_count=1, frame_error=0; 32 bytes read back in order with out_ready held at 1.
- in_status=01 with a valid D0/BA frame, but byte 7 driven as 0x00 -> result_code=00, frame_error=1, err_count=0; with the macro undefined, result_code=01 and err_count=1 instead.
- in_status=11 with in_valid dropping after 20 bytes -> no result_done, frame_error=1, lock_count=0, state back to IDLE, out_valid stays 0.
- Valid win frame with out_ready toggling 1,0,0,1… -> each byte is handed over exactly once and out_data holds while stalled; a second frame started mid-drain -> overrun=1 and win_count stays 1.
- 300 valid lockout frames, each fully drained -> lock_count saturates at 255.
- rst pulsed at byte 10 of a capture -> all outputs 0; the next full valid frame is processed normally.
